// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants and types.
//   MW  : mantissa width including the hidden bit
//   EW  : biased exponent width
//   LZW : width of a leading-zero count / shift amount (holds 0..MW)
package fp_pkg;

  localparam int unsigned MW  = 24;
  localparam int unsigned EW  = 8;
  localparam int unsigned LZW = 5;

  // Classification of a normalizer result.
  typedef enum logic [1:0] {
    RES_NORM,
    RES_UFLOW,
    RES_ZERO
  } res_kind_e;

endpackage

// File: rtl/mant_normalizer_shiftleft.sv
// Combinational logarithmic left barrel shifter, the mirror image of the
// existing right shifter. Zero fill; bits shifted past the MSB are lost.
//   din  : W-bit operand
//   sel  : SW-bit shift amount (stages of 16/8/4/2/1 for SW = 5)
//   dout : din << sel
module shiftleft
  import fp_pkg::*;
#(
  parameter int unsigned W  = fp_pkg::MW,
  parameter int unsigned SW = fp_pkg::LZW
) (
  input  logic [W-1:0]  din,
  input  logic [SW-1:0] sel,
  output logic [W-1:0]  dout
);

  logic [W-1:0] stage;

  // Largest stage first: 16, 8, 4, 2, 1.
  always_comb begin
    stage = din;
    for (int unsigned k = 0; k < SW; k++) begin
      if (sel[SW-1-k]) begin
        stage = stage << (1 << (SW - 1 - k));
      end
    end
    dout = stage;
  end

endmodule

// File: rtl/mant_normalizer.sv
// Two-stage mantissa normalizer with valid/ready handshaking on both sides.
// S1 captures the raw mantissa, exponent and its leading-zero count;
// S2 captures the left-justified mantissa, adjusted exponent and flags.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake
//   in_mant, in_exp      : unnormalized mantissa and its biased exponent
//   out_valid/out_ready  : output handshake
//   out_mant, out_exp    : normalized mantissa and adjusted exponent
//   out_zero             : input mantissa was zero
//   out_uflow            : shift clamped to the exponent; exponent forced to 0
module mant_normalizer #(
  parameter int unsigned MW = fp_pkg::MW,
  parameter int unsigned EW = fp_pkg::EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_zero,
  output logic          out_uflow
);

  import fp_pkg::*;

  logic           s1_valid;
  logic [MW-1:0]  s1_mant;
  logic [EW-1:0]  s1_exp;
  logic [LZW-1:0] s1_lzc;

  logic           s1_load;
  logic           s2_load;
  logic [LZW-1:0] lzc_c;

  res_kind_e      kind;
  logic [EW-1:0]  lzc_ext;
  logic [LZW-1:0] shamt;
  logic [MW-1:0]  shifted;
  logic [MW-1:0]  n_mant;
  logic [EW-1:0]  n_exp;

  assign s2_load  = s1_valid & (~out_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;

  // Leading-zero count: scanning upward, the highest set bit wins.
  always_comb begin
    lzc_c = LZW'(MW);
    for (int unsigned i = 0; i < MW; i++) begin
      if (in_mant[i]) begin
        lzc_c = LZW'(MW - 1 - i);
      end
    end
  end

  // When lzc exceeds the exponent, the exponent is below MW and fits the
  // shift-amount width, so its low bits are the clamped shift.
  always_comb begin
    lzc_ext = EW'(s1_lzc);
    kind    = RES_NORM;
    shamt   = s1_lzc;
    if (s1_mant == '0) begin
      kind  = RES_ZERO;
      shamt = '0;
    end else if (lzc_ext > s1_exp) begin
      kind  = RES_UFLOW;
      shamt = s1_exp[LZW-1:0];
    end
  end

  shiftleft #(
    .W  (MW),
    .SW (LZW)
  ) u_shiftleft (
    .din  (s1_mant),
    .sel  (shamt),
    .dout (shifted)
  );

  always_comb begin
    n_mant = (kind == RES_ZERO) ? '0 : shifted;
    n_exp  = (kind == RES_NORM) ? (s1_exp - lzc_ext) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mant   <= '0;
      s1_exp    <= '0;
      s1_lzc    <= '0;
      out_valid <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
    end else begin
      s1_valid  <= s1_load | (s1_valid & ~s2_load);
      out_valid <= s2_load | (out_valid & ~out_ready);
      if (s1_load) begin
        s1_mant <= in_mant;
        s1_exp  <= in_exp;
        s1_lzc  <= lzc_c;
      end
      if (s2_load) begin
        out_mant  <= n_mant;
        out_exp   <= n_exp;
        out_zero  <= (kind == RES_ZERO);
        out_uflow <= (kind == RES_UFLOW);
      end
    end
  end

endmodule
